// File: rtl/ctrl_table_loader.sv
// ctrl_table_loader
// Control-plane loader for the CGRA. Consumes a valid/ready phit stream and
// writes, in order, the state table, one config table per PE column and the
// inbound buffer, then raises ready_stream_in. Supports zero-length segment
// skipping, a start-time bounds check with a sticky error flag and reload
// from RUN without reset.
module ctrl_table_loader #(
    parameter int PHIT_W  = 512,
    parameter int NUM_COL = 6,
    parameter int CFG_W   = 24,
    parameter int IMM_W   = 64,
    parameter int STATE_W = 48,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_loader,
    input  logic [ADDR_W:0]      num_entry_config_table,
    input  logic [ADDR_W:0]      num_entry_inbound,
    input  logic [PHIT_W-1:0]    in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 state_wr_en,
    output logic [ADDR_W-1:0]    state_wr_addr,
    output logic [STATE_W-1:0]   state_wr_data,
    output logic [NUM_COL-1:0]   cfg_wr_en,
    output logic [ADDR_W-1:0]    cfg_wr_addr,
    output logic [CFG_W-1:0]     cfg_wr_ctrl,
    output logic [IMM_W-1:0]     cfg_wr_imm,
    output logic                 inb_wr_en,
    output logic [ADDR_W-1:0]    inb_wr_addr,
    output logic [PHIT_W-1:0]    inb_wr_data,
    output logic                 ready_stream_in,
    output logic                 load_busy,
    output logic                 load_err
);

    localparam int COL_W = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
    localparam logic [ADDR_W:0]    DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]    ZERO_N   = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]    ONE_N    = (ADDR_W+1)'(1'b1);
    localparam logic [ADDR_W-1:0]  ZERO_E   = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0]  ONE_E    = ADDR_W'(1'b1);
    localparam logic [COL_W-1:0]   ZERO_C   = {COL_W{1'b0}};
    localparam logic [COL_W-1:0]   ONE_C    = COL_W'(1'b1);
    localparam logic [COL_W-1:0]   LAST_COL = COL_W'(NUM_COL-1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD_STATE = 3'd1,
        ST_LOAD_CFG   = 3'd2,
        ST_LOAD_INB   = 3'd3,
        ST_RUN        = 3'd4
    } state_t;

    // One-hot column select for the config table write enables.
    function automatic logic [NUM_COL-1:0] col_onehot(input logic [COL_W-1:0] c);
        logic [NUM_COL-1:0] oh;
        oh = {NUM_COL{1'b0}};
        for (int i = 0; i < NUM_COL; i++) begin
            oh[i] = (c == COL_W'(i));
        end
        return oh;
    endfunction

    // True for the three states that consume phits.
    function automatic logic is_load(input state_t s);
        return (s == ST_LOAD_STATE) || (s == ST_LOAD_CFG) || (s == ST_LOAD_INB);
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   ent_r;
    logic [ADDR_W-1:0]   ent_nxt_s;
    logic [COL_W-1:0]    col_r;
    logic [COL_W-1:0]    col_nxt_s;
    logic [ADDR_W:0]     nc_r;
    logic [ADDR_W:0]     nc_nxt_s;
    logic [ADDR_W:0]     ni_r;
    logic [ADDR_W:0]     ni_nxt_s;
    logic                err_nxt_s;
    logic                load_err_r;
    logic                in_ready_r;
    logic                load_busy_r;
    logic                ready_stream_in_r;
    logic                beat_s;
    logic                last_c_s;
    logic                last_i_s;

    logic                state_wr_en_r;
    logic [ADDR_W-1:0]   state_wr_addr_r;
    logic [STATE_W-1:0]  state_wr_data_r;
    logic [NUM_COL-1:0]  cfg_wr_en_r;
    logic [ADDR_W-1:0]   cfg_wr_addr_r;
    logic [CFG_W-1:0]    cfg_wr_ctrl_r;
    logic [IMM_W-1:0]    cfg_wr_imm_r;
    logic                inb_wr_en_r;
    logic [ADDR_W-1:0]   inb_wr_addr_r;
    logic [PHIT_W-1:0]   inb_wr_data_r;

    // in_ready_r mirrors "state_r is a LOAD state", so this is the accept strobe.
    assign beat_s   = in_valid & in_ready_r;
    assign last_c_s = ({1'b0, ent_r} == (nc_r - ONE_N));
    assign last_i_s = ({1'b0, ent_r} == (ni_r - ONE_N));

    // Next-state and counter logic for the load sequence.
    always_comb begin
        state_nxt_s = state_r;
        ent_nxt_s   = ent_r;
        col_nxt_s   = col_r;
        nc_nxt_s    = nc_r;
        ni_nxt_s    = ni_r;
        err_nxt_s   = load_err_r;
        case (state_r)
            ST_IDLE, ST_RUN: begin
                if (start_loader) begin
                    nc_nxt_s  = num_entry_config_table;
                    ni_nxt_s  = num_entry_inbound;
                    ent_nxt_s = ZERO_E;
                    col_nxt_s = ZERO_C;
                    err_nxt_s = 1'b0;
                    if ((num_entry_config_table > DEPTH_L) || (num_entry_inbound > DEPTH_L)) begin
                        err_nxt_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else if (num_entry_config_table != ZERO_N) begin
                        state_nxt_s = ST_LOAD_STATE;
                    end else if (num_entry_inbound != ZERO_N) begin
                        state_nxt_s = ST_LOAD_INB;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_LOAD_STATE: begin
                if (beat_s) begin
                    if (last_c_s) begin
                        ent_nxt_s   = ZERO_E;
                        state_nxt_s = ST_LOAD_CFG;
                    end else begin
                        ent_nxt_s = ent_r + ONE_E;
                    end
                end else begin
                    ent_nxt_s = ent_r;
                end
            end
            ST_LOAD_CFG: begin
                if (beat_s) begin
                    if (last_c_s) begin
                        ent_nxt_s = ZERO_E;
                        if (col_r == LAST_COL) begin
                            // col stays on the last column rather than overflowing.
                            state_nxt_s = (ni_r != ZERO_N) ? ST_LOAD_INB : ST_RUN;
                        end else begin
                            col_nxt_s = col_r + ONE_C;
                        end
                    end else begin
                        ent_nxt_s = ent_r + ONE_E;
                    end
                end else begin
                    ent_nxt_s = ent_r;
                end
            end
            ST_LOAD_INB: begin
                if (beat_s) begin
                    if (last_i_s) begin
                        ent_nxt_s   = ZERO_E;
                        state_nxt_s = ST_RUN;
                    end else begin
                        ent_nxt_s = ent_r + ONE_E;
                    end
                end else begin
                    ent_nxt_s = ent_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, latched counts and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ent_r      <= ZERO_E;
            col_r      <= ZERO_C;
            nc_r       <= ZERO_N;
            ni_r       <= ZERO_N;
            load_err_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ent_r      <= ent_nxt_s;
            col_r      <= col_nxt_s;
            nc_r       <= nc_nxt_s;
            ni_r       <= ni_nxt_s;
            load_err_r <= err_nxt_s;
        end
    end

    // Status outputs registered from the next state so they align with state_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r        <= 1'b0;
            load_busy_r       <= 1'b0;
            ready_stream_in_r <= 1'b0;
        end else begin
            in_ready_r        <= is_load(state_nxt_s);
            load_busy_r       <= is_load(state_nxt_s);
            ready_stream_in_r <= (state_nxt_s == ST_RUN);
        end
    end

    // Table write ports: one-cycle pulse per accepted beat, address/data held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_wr_en_r   <= 1'b0;
            state_wr_addr_r <= ZERO_E;
            state_wr_data_r <= {STATE_W{1'b0}};
            cfg_wr_en_r     <= {NUM_COL{1'b0}};
            cfg_wr_addr_r   <= ZERO_E;
            cfg_wr_ctrl_r   <= {CFG_W{1'b0}};
            cfg_wr_imm_r    <= {IMM_W{1'b0}};
            inb_wr_en_r     <= 1'b0;
            inb_wr_addr_r   <= ZERO_E;
            inb_wr_data_r   <= {PHIT_W{1'b0}};
        end else begin
            state_wr_en_r <= 1'b0;
            cfg_wr_en_r   <= {NUM_COL{1'b0}};
            inb_wr_en_r   <= 1'b0;
            if (beat_s) begin
                case (state_r)
                    ST_LOAD_STATE: begin
                        state_wr_en_r   <= 1'b1;
                        state_wr_addr_r <= ent_r;
                        state_wr_data_r <= in_data[PHIT_W-1 -: STATE_W];
                    end
                    ST_LOAD_CFG: begin
                        cfg_wr_en_r   <= col_onehot(col_r);
                        cfg_wr_addr_r <= ent_r;
                        cfg_wr_ctrl_r <= in_data[PHIT_W-1 -: CFG_W];
                        cfg_wr_imm_r  <= in_data[IMM_W-1:0];
                    end
                    ST_LOAD_INB: begin
                        inb_wr_en_r   <= 1'b1;
                        inb_wr_addr_r <= ent_r;
                        inb_wr_data_r <= in_data;
                    end
                    default: begin
                        inb_wr_en_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_ready        = in_ready_r;
    assign load_busy       = load_busy_r;
    assign ready_stream_in = ready_stream_in_r;
    assign load_err        = load_err_r;
    assign state_wr_en     = state_wr_en_r;
    assign state_wr_addr   = state_wr_addr_r;
    assign state_wr_data   = state_wr_data_r;
    assign cfg_wr_en       = cfg_wr_en_r;
    assign cfg_wr_addr     = cfg_wr_addr_r;
    assign cfg_wr_ctrl     = cfg_wr_ctrl_r;
    assign cfg_wr_imm      = cfg_wr_imm_r;
    assign inb_wr_en       = inb_wr_en_r;
    assign inb_wr_addr     = inb_wr_addr_r;
    assign inb_wr_data     = inb_wr_data_r;

endmodule
